// File: rtl/bcd_ascii_serializer_if.sv
// Load / byte-stream bundle between the BCD converter, this serializer and the UART TX.
// slave = serializer side, master = upstream/downstream environment side.
interface bcd_ascii_serializer_if #(
    parameter int NUM_DIGITS = 10
);
    logic                    start_i;
    logic [4*NUM_DIGITS-1:0] bcd_i;
    logic                    ready_o;
    logic                    done_o;
    logic [7:0]              tx_data_o;
    logic                    tx_valid_o;
    logic                    tx_ready_i;

    modport slave (
        input  start_i, bcd_i, tx_ready_i,
        output ready_o, done_o, tx_data_o, tx_valid_o
    );

    modport master (
        output start_i, bcd_i, tx_ready_i,
        input  ready_o, done_o, tx_data_o, tx_valid_o
    );
endinterface

// File: rtl/bcd_ascii_serializer.sv
// Streams a packed BCD word as ASCII digits (optional leading-zero suppression)
// followed by optional CR/LF, one byte per valid/ready handshake.
module bcd_ascii_serializer #(
    parameter int NUM_DIGITS     = 10,
    parameter int SUPPRESS_ZEROS = 1,
    parameter int APPEND_CRLF    = 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    bcd_ascii_serializer_if.slave bus
);
    localparam int CW = $clog2(NUM_DIGITS + 1);

    typedef enum logic [2:0] {IDLE, SKIP, SEND, CR, LF, DONE} state_t;

    state_t                  state;
    logic [4*NUM_DIGITS-1:0] shreg;
    logic [CW-1:0]           digit_count;
    logic [3:0]              top_digit;

    assign top_digit = shreg[4*NUM_DIGITS-1 -: 4];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state       <= IDLE;
            shreg       <= '0;
            digit_count <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start_i) begin
                    shreg       <= bus.bcd_i;
                    digit_count <= CW'(NUM_DIGITS);
                    state       <= SKIP;
                end
                // One leading zero dropped per cycle; the last digit is never dropped.
                SKIP: if (SUPPRESS_ZEROS != 0 && top_digit == 4'h0 && digit_count > CW'(1)) begin
                    shreg       <= shreg << 4;
                    digit_count <= digit_count - CW'(1);
                end else begin
                    state <= SEND;
                end
                SEND: if (bus.tx_ready_i) begin
                    if (digit_count > CW'(1)) begin
                        shreg       <= shreg << 4;
                        digit_count <= digit_count - CW'(1);
                    end else begin
                        state <= (APPEND_CRLF != 0) ? CR : DONE;
                    end
                end
                CR:      if (bus.tx_ready_i) state <= LF;
                LF:      if (bus.tx_ready_i) state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs depend on registered state only, so backpressure never glitches them.
    always_comb begin
        bus.ready_o    = (state == IDLE);
        bus.done_o     = (state == DONE);
        bus.tx_valid_o = (state == SEND) || (state == CR) || (state == LF);
        bus.tx_data_o  = 8'h00;
        case (state)
            SEND:    bus.tx_data_o = (top_digit > 4'd9) ? 8'h3F : {4'h3, top_digit};
            CR:      bus.tx_data_o = 8'h0D;
            LF:      bus.tx_data_o = 8'h0A;
            default: bus.tx_data_o = 8'h00;
        endcase
    end
endmodule

// File: tb/tb_bcd_ascii_serializer.sv
// Directed bench: a byte scoreboard filled from a reference model at load time and
// drained by a monitor on every accepted byte, plus latency/done/reset checks.
module tb_bcd_ascii_serializer;
    localparam int ND = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bcd_ascii_serializer_if #(.NUM_DIGITS(ND)) bus ();

    bcd_ascii_serializer #(.NUM_DIGITS(ND), .SUPPRESS_ZEROS(1), .APPEND_CRLF(1)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: ASCII digits with leading zeros dropped (keep the last), then CR LF.
    task automatic push_model(input logic [4*ND-1:0] w);
        bit started = 0;
        logic [3:0] d;
        for (int i = ND - 1; i >= 0; i--) begin
            d = w[4*i +: 4];
            if (!started && d == 4'h0 && i > 0) continue;
            started = 1;
            exp_q.push_back((d > 4'd9) ? 8'h3F : (8'h30 + {4'h0, d}));
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    // Monitor: sampled mid-cycle, so valid/ready here decide the next rising edge.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    always @(negedge clk) begin
        if (prev_stall) begin
            chk("stall_valid", 32'(bus.tx_valid_o), 32'h1);
            chk("stall_data", 32'(bus.tx_data_o), 32'(prev_data));
        end
        if (bus.tx_valid_o && bus.tx_ready_i && !reset) begin
            if (exp_q.size() == 0) chk("unexpected_byte", 32'(bus.tx_data_o), 32'hFFFF_FFFF);
            else chk("byte", 32'(bus.tx_data_o), 32'(exp_q.pop_front()));
        end
        prev_stall = bus.tx_valid_o && !bus.tx_ready_i && !reset;
        prev_data  = bus.tx_data_o;
        if (bus.done_o) done_cnt++;
    end

    // Loads w, checks first-valid latency, streams to completion and checks done timing.
    // Edges are counted from the accepting edge: first byte visible after z+1 edges,
    // done_o visible after z+1+d+2 edges.
    task automatic run_txn(input logic [4*ND-1:0] w, input int exp_lat, input int exp_done,
                           input bit bp, input bit poke);
        int e = 0;
        int k = 0;
        int w8 = 0;
        int d0 = done_cnt;
        logic [3:0] pat = 4'b1001;
        while (!bus.ready_o && w8 < 50) begin @(posedge clk); #1; w8++; end
        chk("ready_before_start", 32'(bus.ready_o), 32'h1);
        bus.start_i = 1'b1;
        bus.bcd_i   = w;
        push_model(w);
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        bus.bcd_i   = '0;
        chk("ready_busy", 32'(bus.ready_o), 32'h0);
        while (!bus.tx_valid_o && e < 200) begin @(posedge clk); #1; e++; end
        chk("first_valid_latency", 32'(e), 32'(exp_lat));
        while (!bus.done_o && e < 400) begin
            if (bp) bus.tx_ready_i = pat[k % 4];
            if (poke && k == 1) begin bus.start_i = 1'b1; bus.bcd_i = 40'h11_1111_1111; end
            if (poke && k == 2) begin bus.start_i = 1'b0; bus.bcd_i = '0; end
            k++;
            @(posedge clk); #1; e++;
        end
        bus.tx_ready_i = 1'b1;
        bus.start_i    = 1'b0;
        chk("done_seen", 32'(bus.done_o), 32'h1);
        if (!bp) chk("done_latency", 32'(e), 32'(exp_done));
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(bus.done_o), 32'h0);
        chk("ready_returns", 32'(bus.ready_o), 32'h1);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        chk("done_count", 32'(done_cnt - d0), 32'h1);
    endtask

    initial begin
        int e;
        int d0;
        bus.start_i    = 1'b0;
        bus.bcd_i      = '0;
        bus.tx_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.ready_o), 32'h1);
        chk("rst_valid", 32'(bus.tx_valid_o), 32'h0);
        chk("rst_done", 32'(bus.done_o), 32'h0);
        chk("rst_data", 32'(bus.tx_data_o), 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_txn(40'h00_0000_0042, 9, 13, 1'b0, 1'b0);   // z=8, d=2
        run_txn(40'h00_0000_0000, 10, 13, 1'b0, 1'b0);  // z=9, d=1
        run_txn(40'h98_7654_3210, 1, 13, 1'b0, 1'b0);   // z=0, d=10
        run_txn(40'h00_0000_1005, 7, 0, 1'b1, 1'b0);    // backpressure 1,0,0,1
        run_txn(40'h00_0000_00A7, 9, 13, 1'b0, 1'b1);   // '?' digit, stray start

        // Reset while the second digit is on the bus.
        bus.start_i = 1'b1;
        bus.bcd_i   = 40'h12_3456_7890;
        push_model(40'h12_3456_7890);
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        e = 0;
        while (!(bus.tx_valid_o && bus.tx_data_o == 8'h32) && e < 50) begin @(posedge clk); #1; e++; end
        chk("second_digit_reached", 32'(bus.tx_data_o), 32'h32);
        d0 = done_cnt;
        reset       = 1'b1;
        bus.start_i = 1'b1;
        bus.bcd_i   = 40'h5;
        @(posedge clk); #1;
        reset       = 1'b0;
        bus.start_i = 1'b0;
        chk("rst_mid_valid", 32'(bus.tx_valid_o), 32'h0);
        chk("rst_mid_ready", 32'(bus.ready_o), 32'h1);
        chk("rst_mid_remaining", 32'(exp_q.size()), 32'd11);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid_no_done", 32'(done_cnt - d0), 32'h0);
        chk("rst_mid_idle_valid", 32'(bus.tx_valid_o), 32'h0);
        run_txn(40'h00_0000_0005, 10, 13, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
